// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges per-stage stall requests into a hold vector, drives
// branch flush / PC redirect, and keeps a stall watchdog plus perf counters.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES  = 2,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stallreq_i,
    input  logic             id_stallreq_i,
    input  logic             ex_stallreq_i,
    input  logic             mem_stallreq_i,
    input  logic             ex_branch_flag_i,
    input  logic [31:0]      ex_branch_addr_i,
    input  logic             err_clr_i,
    output logic [2:0]       stalled_o,
    output logic             flush_o,
    output logic             pc_load_o,
    output logic [31:0]      new_pc_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int SW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t        state;
    logic [SW-1:0] scnt;
    logic [2:0]    fcnt;
    logic [31:0]   new_pc_q;
    logic [2:0]    mask;
    logic          br_take;
    logic          stall_act;
    logic          tmo_set;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A branch only resolves once EX is free to move, so it never coexists with an ex/mem hold.
    always_comb begin
        mask = 3'b000;
        if (mem_stallreq_i)
            mask = mask | 3'b111;
        if (ex_stallreq_i)
            mask = mask | 3'b011;
        if (id_stallreq_i || if_stallreq_i)
            mask = mask | 3'b001;
        br_take   = ex_branch_flag_i & ~ex_stallreq_i & ~mem_stallreq_i & ~rst;
        stalled_o = (br_take || rst) ? 3'b000 : mask;
        stall_act = (stalled_o != 3'b000);
        flush_o   = ~rst & (br_take | (state == FLUSH));
        pc_load_o = br_take;
        new_pc_o  = br_take ? ex_branch_addr_i : new_pc_q;
        tmo_set   = (state == STALL) && !br_take && stall_act && (scnt == SW'(STALL_TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            scnt        <= '0;
            fcnt        <= '0;
            new_pc_q    <= '0;
            timeout_o   <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (br_take) begin
                new_pc_q    <= ex_branch_addr_i;
                flush_cnt_o <= sat_inc(flush_cnt_o);
            end
            if (stall_act)
                stall_cnt_o <= sat_inc(stall_cnt_o);
            // Set is evaluated last so it wins over a simultaneous clear.
            if (err_clr_i)
                timeout_o <= 1'b0;
            if (tmo_set)
                timeout_o <= 1'b1;

            if (br_take) begin
                scnt <= '0;
                fcnt <= 3'(FLUSH_CYCLES - 1);
                state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (stall_act) begin
                            state <= STALL;
                            scnt  <= SW'(1);
                        end
                    end
                    STALL: begin
                        if (stall_act) begin
                            if (scnt != SW'(STALL_TIMEOUT))
                                scnt <= scnt + 1'b1;
                        end else begin
                            state <= RUN;
                            scnt  <= '0;
                        end
                    end
                    FLUSH: begin
                        if (fcnt <= 3'd1) begin
                            fcnt  <= '0;
                            state <= stall_act ? STALL : RUN;
                            scnt  <= stall_act ? SW'(1) : '0;
                        end else begin
                            fcnt <= fcnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= RUN;
                        scnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (FLUSH_CYCLES=2, STALL_TIMEOUT=4).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, id_req, ex_req, mem_req, br_flag, err_clr;
    logic [31:0] br_addr;
    logic [2:0]  stalled;
    logic        flush, pc_load, timeout;
    logic [31:0] new_pc, stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_ctrl #(.FLUSH_CYCLES(2), .STALL_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_stallreq_i(if_req), .id_stallreq_i(id_req),
        .ex_stallreq_i(ex_req), .mem_stallreq_i(mem_req),
        .ex_branch_flag_i(br_flag), .ex_branch_addr_i(br_addr),
        .err_clr_i(err_clr),
        .stalled_o(stalled), .flush_o(flush), .pc_load_o(pc_load),
        .new_pc_o(new_pc), .timeout_o(timeout),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; id_req = 0; ex_req = 0; mem_req = 0;
        br_flag = 0; br_addr = 32'h0; err_clr = 0;
        #1;
        check("rst_stalled", 32'(stalled), 32'h0);
        check("rst_flush",   32'(flush),   32'h0);
        check("rst_pcload",  32'(pc_load), 32'h0);
        check("rst_newpc",   new_pc,       32'h0);
        check("rst_cnts",    stall_cnt | flush_cnt, 32'h0);
        step(); step();
        rst = 1'b0;
        step();

        // T1: load-use hold for three cycles
        id_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("t1_stalled", 32'(stalled), 32'h1);
            step();
        end
        id_req = 0;
        #1 check("t1_release", 32'(stalled), 32'h0);
        check("t1_stall_cnt", stall_cnt, 32'd3);
        step();
        check("t1_timeout", 32'(timeout), 32'h0);

        // T2: branch waits behind a mem stall, then redirects
        mem_req = 1; br_flag = 1; br_addr = 32'h80;
        for (int i = 0; i < 2; i++) begin
            #1 check("t2_stalled", 32'(stalled), 32'h7);
            check("t2_no_pcload", 32'(pc_load), 32'h0);
            check("t2_no_flush",  32'(flush),   32'h0);
            step();
        end
        mem_req = 0;
        #1 check("t2_pcload", 32'(pc_load), 32'h1);
        check("t2_newpc",   new_pc,       32'h80);
        check("t2_flush1",  32'(flush),   32'h1);
        check("t2_stall0",  32'(stalled), 32'h0);
        step();
        br_flag = 0; br_addr = 32'h0;
        #1 check("t2_flush2", 32'(flush),   32'h1);
        check("t2_pcload_off", 32'(pc_load), 32'h0);
        check("t2_newpc_held", new_pc,       32'h80);
        check("t2_flush_cnt",  flush_cnt,    32'd1);
        step();
        check("t2_flush_end", 32'(flush), 32'h0);
        check("t2_stall_cnt", stall_cnt,  32'd5);

        // T3: branch beats a same-cycle ID stall
        id_req = 1; br_flag = 1; br_addr = 32'h40;
        #1 check("t3_stalled", 32'(stalled), 32'h0);
        check("t3_flush",  32'(flush),   32'h1);
        check("t3_pcload", 32'(pc_load), 32'h1);
        check("t3_newpc",  new_pc,       32'h40);
        step();
        id_req = 0; br_flag = 0;
        step();
        check("t3_flush_end", 32'(flush), 32'h0);
        check("t3_flush_cnt", flush_cnt,  32'd2);

        // T4: watchdog on a long EX hold
        ex_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check("t4_stalled", 32'(stalled), 32'h3);
            check("t4_no_tmo", 32'(timeout), 32'h0);
            step();
        end
        check("t4_timeout",   32'(timeout), 32'h1);
        check("t4_still_hold", 32'(stalled), 32'h3);
        ex_req = 0;
        step();
        check("t4_sticky", 32'(timeout), 32'h1);
        check("t4_stall_cnt", stall_cnt, 32'd9);
        err_clr = 1;
        step();
        err_clr = 0;
        check("t4_cleared", 32'(timeout), 32'h0);

        // T5: second branch during FLUSH restarts the flush window
        br_flag = 1; br_addr = 32'h200;
        #1 check("t5_pcload1", 32'(pc_load), 32'h1);
        step();
        br_addr = 32'h100;
        #1 check("t5_pcload2", 32'(pc_load), 32'h1);
        check("t5_newpc2", new_pc,     32'h100);
        check("t5_flush",  32'(flush), 32'h1);
        step();
        br_flag = 0; br_addr = 32'h0;
        #1 check("t5_flush_ext", 32'(flush),   32'h1);
        check("t5_pcload_off", 32'(pc_load), 32'h0);
        check("t5_newpc_held", new_pc,       32'h100);
        step();
        check("t5_flush_end", 32'(flush), 32'h0);
        check("t5_flush_cnt", flush_cnt,  32'd4);

        // T6: async reset in the middle of a stall
        ex_req = 1;
        step(); step();
        check("t6_pre_stalled", 32'(stalled), 32'h3);
        #2 rst = 1'b1;
        #1 check("t6_stalled", 32'(stalled), 32'h0);
        check("t6_stall_cnt", stall_cnt,     32'h0);
        check("t6_flush_cnt", flush_cnt,     32'h0);
        check("t6_timeout",   32'(timeout),  32'h0);
        ex_req = 0;
        step();
        rst = 1'b0;
        step();
        check("t6_run_flush", 32'(flush), 32'h0);
        id_req = 1;
        step();
        id_req = 0;
        check("t6_restart_cnt", stall_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
